data_mem_access_unit: RTL and testbench
=======================================

// Module: data_mem_access_unit
// PURPOSE
//  Data-memory port controller sitting directly downstream of the memory-operation decoder.
//  Consumes the decoded L / WB / D request plus the effective address and write data.
//  Performs a byte, halfword, word or doubleword access to an internal byte-addressed RAM with
//  a programmable wait-state count. Completion is signalled to the control unit through an
//  MFA/MOC four-phase handshake.
// PARAMETERS
//  ADDR_W       8   byte-address width; RAM depth = 2**ADDR_W bytes
//  WAIT_CYCLES  2   wait-state cycles per beat (0 allowed = no wait state)
// PORTS
//  clk       in   1       single clock, rising edge
//  reset     in   1       synchronous, active-high
//  mfa       in   1       memory function active (request), level
//  l         in   1       1 = load/read, 0 = store/write
//  wb        in   2       size: 2'b10 word, 2'b01 byte, 2'b00 halfword (when d=0)
//  d         in   1       1 = doubleword (overrides wb)
//  sgn       in   1       loads only: 1 = sign-extend byte/halfword, 0 = zero-extend
//  addr      in   ADDR_W  byte address
//  data_in   in   32      store data (word 0 for doubleword)
//  data_in_hi in  32      store data, word 1 (doubleword only)
//  data_out  out  32      load data (word 0 for doubleword)
//  data_out_hi out 32     load data, word 1 (doubleword only)
//  moc       out  1       memory operation complete
//  err       out  1       alignment fault on completed request
// BEHAVIOUR
//  - Reset: state IDLE, moc=0, err=0, data_out=0, data_out_hi=0. RAM contents are not reset.
//  - Memory is big-endian: a word at A holds mem[A] in [31:24] through mem[A+3] in [7:0].
//  - States: IDLE, WAIT, XFER, DONE. Beat counter (0/1) and wait counter are internal.
//  - IDLE: on mfa=1, latch l/wb/d/sgn/addr/data_in/data_in_hi and clear err.
//      Misaligned request -> DONE with err=1, no RAM access.
//      Misaligned means: halfword with addr[0]!=0; word with addr[1:0]!=0;
//      doubleword with addr[2:0]!=0.
//      Aligned request -> WAIT, or XFER directly if WAIT_CYCLES=0.
//  - WAIT: stays exactly WAIT_CYCLES cycles, then -> XFER.
//  - XFER, 1 cycle:
//      Write: RAM written at latched addr, plus 4 on beat 1.
//      Read: data_out (beat 0) or data_out_hi (beat 1) loaded.
//      Doubleword with beat 0 -> beat=1, then back to WAIT/XFER. Otherwise -> DONE.
//  - Byte store writes 1 byte and halfword store writes 2 bytes from the data_in LSBs.
//    Other RAM bytes are untouched.
//  - Byte/halfword load: extends to 32 bits per latched sgn. data_out_hi is unchanged
//    by non-doubleword reads.
//  - DONE: moc=1 (registered). Leaves to IDLE on the first sampled mfa=0, and moc=0 in that
//    next cycle. If mfa is already low on entry, moc is high for exactly 1 cycle.
//  - Latency, with request sampled at edge 0:
//      Single beat: moc rises after edge WAIT_CYCLES+1.
//      Doubleword: moc rises after edge 2*(WAIT_CYCLES+1).
//      Misaligned: moc rises after edge 1.
//  - Inputs changing after acceptance are ignored; only latched values are used.
//  - mfa dropping before moc does not abort the access. A new request is accepted only in IDLE.
//  - Stores leave data_out/data_out_hi unchanged. Outputs hold their values until the next
//    load's XFER.
//  - Address arithmetic wraps modulo 2**ADDR_W, including addr+4 and byte offsets within a word.
//  - Reset mid-operation returns to IDLE immediately.
//      A beat whose XFER has already completed keeps its write.
//      A pending beat is never written.
// TESTING
//  1. Word store then load: store 0xDEADBEEF at 0x10, then load 0x10 (sgn=0).
//     -> data_out=0xDEADBEEF; mem[0x10]=0xDE; moc rises 3 edges after mfa (WAIT_CYCLES=2).
//  2. Byte/halfword loads after test 1:
//     - Byte load 0x11 with sgn=1 -> data_out=0xFFFFFFAD.
//     - Byte load 0x11 with sgn=0 -> data_out=0x000000AD.
//     - Halfword load 0x12 with sgn=1 -> data_out=0xFFFFBEEF.
//  3. Doubleword store {0x11111111, 0x22222222} at 0x20, then doubleword load at 0x20.
//     -> data_out=0x11111111, data_out_hi=0x22222222; moc after edge 6.
//     -> word load 0x24 returns 0x22222222.
//  4. Misaligned accesses:
//     - Word store at 0x13 -> err=1 and moc after edge 1; mem[0x13] unchanged.
//     - Next aligned load -> err=0.
//  5. Handshake and wrap:
//     - mfa held high 4 cycles past moc -> moc stays high until 1 cycle after mfa falls;
//       no second access.
//     - Word store at 0xFC then doubleword access at 0xF8 touches 0xF8–0xFF only.
//  6. Reset in WAIT of a word store to 0x30 -> state IDLE, moc=0, mem[0x30..0x33] unchanged.

Source files
------------

// File: rtl/data_mem_access_if.sv
// Request/response bundle between the control unit and the data-memory port controller.
// The control unit is the master; the memory access unit is the slave.
interface data_mem_access_if #(
  parameter int ADDR_W = 8
);
  logic              mfa;
  logic              l;
  logic [1:0]        wb;
  logic              d;
  logic              sgn;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_in_hi;
  logic [31:0]       data_out;
  logic [31:0]       data_out_hi;
  logic              moc;
  logic              err;

  modport master (
    output mfa, l, wb, d, sgn, addr, data_in, data_in_hi,
    input  data_out, data_out_hi, moc, err
  );

  modport slave (
    input  mfa, l, wb, d, sgn, addr, data_in, data_in_hi,
    output data_out, data_out_hi, moc, err
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Data-memory port controller: byte/halfword/word/doubleword access to a big-endian byte RAM
// with programmable wait states, completed through an MFA/MOC four-phase handshake.
module data_mem_access_unit #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  data_mem_access_if.slave  bus
);

  localparam int WCW   = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_DONE} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} size_e;

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic              beat_q, beat_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic              load_q, load_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       wdata_hi_q, wdata_hi_d;
  logic [31:0]       data_out_q, data_out_d;
  logic [31:0]       data_out_hi_q, data_out_hi_d;
  logic              moc_q, moc_d;
  logic              err_q, err_d;

  logic [7:0]        mem_q [DEPTH];

  size_e             req_size;
  logic              req_misaligned;
  logic [ADDR_W-1:0] beat_addr;
  logic [31:0]       beat_wdata;
  logic [ADDR_W-1:0] lane_addr [4];
  logic [7:0]        rd_byte   [4];
  logic [7:0]        wr_byte   [4];
  logic              lane_we   [4];
  logic [31:0]       rd_word;
  logic [31:0]       load_value;
  logic              mem_write;

  // Request decode straight from the bus; only used on the accepting cycle.
  always_comb begin
    if (bus.d) begin
      req_size = SZ_DWORD;
    end else begin
      case (bus.wb)
        2'b01:   req_size = SZ_BYTE;
        2'b00:   req_size = SZ_HALF;
        default: req_size = SZ_WORD;
      endcase
    end
    case (req_size)
      SZ_HALF:  req_misaligned = bus.addr[0];
      SZ_WORD:  req_misaligned = |bus.addr[1:0];
      SZ_DWORD: req_misaligned = |bus.addr[2:0];
      default:  req_misaligned = 1'b0;
    endcase
  end

  // Byte lanes of the current beat; lane 0 is the most significant byte (big-endian).
  assign beat_addr  = addr_q + (beat_q ? ADDR_W'(4) : ADDR_W'(0));
  assign beat_wdata = beat_q ? wdata_hi_q : wdata_q;
  assign mem_write  = (state_q == ST_XFER) && !load_q && !reset;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = beat_addr + ADDR_W'(k);
      rd_byte[k]   = mem_q[lane_addr[k]];
      wr_byte[k]   = beat_wdata[31-8*k -: 8];
      lane_we[k]   = mem_write;
    end
    rd_word = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    // Narrow stores take their bytes from the LSBs of the store data.
    case (size_q)
      SZ_BYTE: begin
        wr_byte[0] = beat_wdata[7:0];
        lane_we[1] = 1'b0;
        lane_we[2] = 1'b0;
        lane_we[3] = 1'b0;
        load_value = {{24{rd_byte[0][7] & sgn_q}}, rd_byte[0]};
      end
      SZ_HALF: begin
        wr_byte[0] = beat_wdata[15:8];
        wr_byte[1] = beat_wdata[7:0];
        lane_we[2] = 1'b0;
        lane_we[3] = 1'b0;
        load_value = {{16{rd_byte[0][7] & sgn_q}}, rd_byte[0], rd_byte[1]};
      end
      default: load_value = rd_word;
    endcase
  end

  // NOTE: every _d gets its default from the _q value first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    beat_d        = beat_q;
    wait_cnt_d    = wait_cnt_q;
    load_d        = load_q;
    sgn_d         = sgn_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wdata_hi_d    = wdata_hi_q;
    data_out_d    = data_out_q;
    data_out_hi_d = data_out_hi_q;
    moc_d         = moc_q;
    err_d         = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.mfa) begin
          load_d     = bus.l;
          size_d     = req_size;
          sgn_d      = bus.sgn;
          addr_d     = bus.addr;
          wdata_d    = bus.data_in;
          wdata_hi_d = bus.data_in_hi;
          beat_d     = 1'b0;
          wait_cnt_d = '0;
          err_d      = req_misaligned;
          if (req_misaligned)        state_d = ST_DONE;
          else if (WAIT_CYCLES == 0) state_d = ST_XFER;
          else                       state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == WCW'(WAIT_CYCLES - 1)) begin
          wait_cnt_d = '0;
          state_d    = ST_XFER;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      ST_XFER: begin
        if (load_q) begin
          if (beat_q) data_out_hi_d = rd_word;
          else        data_out_d    = load_value;
        end
        if ((size_q == SZ_DWORD) && !beat_q) begin
          beat_d     = 1'b1;
          wait_cnt_d = '0;
          state_d    = (WAIT_CYCLES == 0) ? ST_XFER : ST_WAIT;
        end else begin
          moc_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // A misaligned request enters here with moc low; it is raised one cycle later and
        // the exit waits until moc has actually been seen high.
        moc_d = 1'b1;
        if (moc_q && !bus.mfa) begin
          moc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      size_q        <= SZ_BYTE;
      beat_q        <= 1'b0;
      wait_cnt_q    <= '0;
      load_q        <= 1'b0;
      sgn_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wdata_hi_q    <= '0;
      data_out_q    <= '0;
      data_out_hi_q <= '0;
      moc_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      beat_q        <= beat_d;
      wait_cnt_q    <= wait_cnt_d;
      load_q        <= load_d;
      sgn_q         <= sgn_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wdata_hi_q    <= wdata_hi_d;
      data_out_q    <= data_out_d;
      data_out_hi_q <= data_out_hi_d;
      moc_q         <= moc_d;
      err_q         <= err_d;
    end
  end

  // NOTE: the RAM array has no reset branch; clearing it would turn it into flops and its
  // contents are undefined after power-up anyway. Writes are still blocked while reset is high.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) mem_q[lane_addr[k]] <= wr_byte[k];
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_out_hi = data_out_hi_q;
  assign bus.moc         = moc_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit (ADDR_W=8, WAIT_CYCLES=2): hand-computed loads,
// stores, latencies, alignment faults, handshake hold and mid-operation reset.
module tb_data_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  data_mem_access_if #(.ADDR_W(8)) bus ();

  data_mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] WB_WORD = 2'b10;
  localparam logic [1:0] WB_BYTE = 2'b01;
  localparam logic [1:0] WB_HALF = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete handshake. The request is sampled at edge 0; the inputs are scrambled right
  // after it. mfa stays high until moc, then for 'hold' more cycles, then drops.
  task automatic access(input string tag, input logic ld, input logic [1:0] wbv,
                        input logic dv, input logic sg, input logic [7:0] a,
                        input logic [31:0] di, input logic [31:0] dihi,
                        input int exp_lat, input logic exp_err, input int hold);
    int lat;
    lat = -1;
    @(negedge clk);
    bus.l = ld; bus.wb = wbv; bus.d = dv; bus.sgn = sg; bus.addr = a;
    bus.data_in = di; bus.data_in_hi = dihi; bus.mfa = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.l = ~ld; bus.wb = ~wbv; bus.sgn = ~sg; bus.addr = ~a;
        bus.data_in = ~di; bus.data_in_hi = ~dihi;
      end
      if (bus.moc === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " err"}, 64'(bus.err), 64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " moc held"}, 64'(bus.moc), 64'd1);
    end
    @(negedge clk);
    bus.mfa = 1'b0;
    @(posedge clk); #1;
    check({tag, " moc release"}, 64'(bus.moc), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.mfa = 1'b0; bus.l = 1'b0; bus.wb = 2'b00; bus.d = 1'b0; bus.sgn = 1'b0;
    bus.addr = '0; bus.data_in = '0; bus.data_in_hi = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset moc", 64'(bus.moc), 64'd0);
    check("reset err", 64'(bus.err), 64'd0);
    check("reset data_out", 64'(bus.data_out), 64'd0);
    check("reset data_out_hi", 64'(bus.data_out_hi), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word store then load
    access("st w 10", 1'b0, WB_WORD, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 3, 1'b0, 0);
    check("store keeps data_out", 64'(bus.data_out), 64'd0);
    access("ld w 10", 1'b1, WB_WORD, 1'b0, 1'b0, 8'h10, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld w 10 data", 64'(bus.data_out), 64'hDEADBEEF);
    access("ld b 10", 1'b1, WB_BYTE, 1'b0, 1'b0, 8'h10, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld b 10 data", 64'(bus.data_out), 64'h000000DE);

    // Narrow loads with sign/zero extension
    access("ld b 11 s", 1'b1, WB_BYTE, 1'b0, 1'b1, 8'h11, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld b 11 s data", 64'(bus.data_out), 64'hFFFFFFAD);
    access("ld b 11 u", 1'b1, WB_BYTE, 1'b0, 1'b0, 8'h11, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld b 11 u data", 64'(bus.data_out), 64'h000000AD);
    access("ld h 12 s", 1'b1, WB_HALF, 1'b0, 1'b1, 8'h12, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld h 12 s data", 64'(bus.data_out), 64'hFFFFBEEF);
    check("narrow ld keeps hi", 64'(bus.data_out_hi), 64'd0);

    // Narrow store touches only its bytes
    access("st b 17", 1'b0, WB_BYTE, 1'b0, 1'b0, 8'h17, 32'h123456A7, 32'h0, 3, 1'b0, 0);
    access("st h 14", 1'b0, WB_HALF, 1'b0, 1'b0, 8'h14, 32'hFFFF5566, 32'h0, 3, 1'b0, 0);
    access("ld w 14", 1'b1, WB_WORD, 1'b0, 1'b0, 8'h14, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld w 14 data", 64'({bus.data_out[31:16], bus.data_out[7:0]}), 64'h5566A7);

    // Doubleword
    access("st d 20", 1'b0, 2'b00, 1'b1, 1'b0, 8'h20, 32'h11111111, 32'h22222222, 6, 1'b0, 0);
    access("ld d 20", 1'b1, 2'b00, 1'b1, 1'b0, 8'h20, 32'h0, 32'h0, 6, 1'b0, 0);
    check("ld d 20 lo", 64'(bus.data_out), 64'h11111111);
    check("ld d 20 hi", 64'(bus.data_out_hi), 64'h22222222);
    access("ld w 24", 1'b1, WB_WORD, 1'b0, 1'b0, 8'h24, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld w 24 data", 64'(bus.data_out), 64'h22222222);

    // Misaligned requests
    access("st w 13 mis", 1'b0, WB_WORD, 1'b0, 1'b0, 8'h13, 32'h12345678, 32'h0, 1, 1'b1, 0);
    access("ld b 13", 1'b1, WB_BYTE, 1'b0, 1'b0, 8'h13, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld b 13 data", 64'(bus.data_out), 64'h000000EF);
    access("ld h 11 mis", 1'b1, WB_HALF, 1'b0, 1'b0, 8'h11, 32'h0, 32'h0, 1, 1'b1, 0);
    check("mis ld keeps data", 64'(bus.data_out), 64'h000000EF);
    access("ld d 24 mis", 1'b1, 2'b00, 1'b1, 1'b0, 8'h24, 32'h0, 32'h0, 1, 1'b1, 0);

    // Handshake: mfa held past moc, then no second access
    access("ld w 10 hold", 1'b1, WB_WORD, 1'b0, 1'b0, 8'h10, 32'h0, 32'h0, 3, 1'b0, 4);
    check("hold data", 64'(bus.data_out), 64'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    check("no second access", 64'(bus.moc), 64'd0);

    // Top-of-memory doubleword
    access("st w f8", 1'b0, WB_WORD, 1'b0, 1'b0, 8'hF8, 32'h01020304, 32'h0, 3, 1'b0, 0);
    access("st w fc", 1'b0, WB_WORD, 1'b0, 1'b0, 8'hFC, 32'hCAFEF00D, 32'h0, 3, 1'b0, 0);
    access("st w 00", 1'b0, WB_WORD, 1'b0, 1'b0, 8'h00, 32'hA5A5A5A5, 32'h0, 3, 1'b0, 0);
    access("ld d f8", 1'b1, 2'b00, 1'b1, 1'b0, 8'hF8, 32'h0, 32'h0, 6, 1'b0, 0);
    check("ld d f8 lo", 64'(bus.data_out), 64'h01020304);
    check("ld d f8 hi", 64'(bus.data_out_hi), 64'hCAFEF00D);
    access("st d f8", 1'b0, 2'b00, 1'b1, 1'b0, 8'hF8, 32'h55667788, 32'h99AABBCC, 6, 1'b0, 0);
    access("ld w 00", 1'b1, WB_WORD, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld w 00 data", 64'(bus.data_out), 64'hA5A5A5A5);
    check("word ld keeps hi", 64'(bus.data_out_hi), 64'hCAFEF00D);
    access("ld w fc", 1'b1, WB_WORD, 1'b0, 1'b0, 8'hFC, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld w fc data", 64'(bus.data_out), 64'h99AABBCC);

    // Reset during the wait state of a store
    access("st w 30", 1'b0, WB_WORD, 1'b0, 1'b0, 8'h30, 32'h0BADF00D, 32'h0, 3, 1'b0, 0);
    @(negedge clk);
    bus.l = 1'b0; bus.wb = WB_WORD; bus.d = 1'b0; bus.addr = 8'h30;
    bus.data_in = 32'hFFFFFFFF; bus.mfa = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mfa = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid reset moc", 64'(bus.moc), 64'd0);
    check("mid reset data_out", 64'(bus.data_out), 64'd0);
    check("mid reset data_out_hi", 64'(bus.data_out_hi), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("after reset idle moc", 64'(bus.moc), 64'd0);
    access("ld w 30", 1'b1, WB_WORD, 1'b0, 1'b0, 8'h30, 32'h0, 32'h0, 3, 1'b0, 0);
    check("ld w 30 data", 64'(bus.data_out), 64'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
